// File: rtl/regime_scheduler_pkg.sv
// rtl/regime_scheduler_pkg.sv - shared codes, state encoding and constants for the regime scheduler
package regime_scheduler_pkg;

    localparam logic [1:0] REGIME_OFF     = 2'd0;
    localparam logic [1:0] REGIME_ENUM    = 2'd1;
    localparam logic [1:0] REGIME_COUNT   = 2'd2;
    localparam logic [1:0] REGIME_REFRESH = 2'd3;

    localparam int GNT_ENUM    = 0;
    localparam int GNT_COUNT   = 1;
    localparam int GNT_REFRESH = 2;

    // Number of LAUNCH cycles allowed for the control path to echo the regime.
    localparam logic [2:0] LAUNCH_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LAUNCH      = 3'd1,
        ST_ENUM_START  = 3'd2,
        ST_RUN_ENUM    = 3'd3,
        ST_RUN_COUNT   = 3'd4,
        ST_DRAIN       = 3'd5,
        ST_RUN_REFRESH = 3'd6
    } state_t;

    // Map a one-hot grant vector to the regime code driven on the control path.
    function automatic logic [1:0] grant_to_regime(input logic [2:0] g);
        logic [1:0] code;
        code = REGIME_OFF;
        if (g[GNT_REFRESH]) begin
            code = REGIME_REFRESH;
        end else if (g[GNT_COUNT]) begin
            code = REGIME_COUNT;
        end else if (g[GNT_ENUM]) begin
            code = REGIME_ENUM;
        end
        return code;
    endfunction

endpackage

// File: rtl/regime_scheduler_refresh_timer.sv
// rtl/regime_scheduler_refresh_timer.sv - auto-refresh interval timer and pending flag
module refresh_timer
    import regime_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] refresh_period,
    input  logic       refresh_grant,
    output logic       refresh_pending
);

    logic [7:0] timer_q, timer_d;
    logic       pending_q, pending_d;

    // Reload on a refresh grant, otherwise count down and flag expiry once at zero.
    // A period of 0 reloads to 0, which never produces a 1->0 step, so it never flags.
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        if (refresh_grant) begin
            timer_d   = refresh_period;
            pending_d = 1'b0;
        end else if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
            if (timer_q == 8'd1) begin
                pending_d = 1'b1;
            end
        end
    end

    // Timer and pending flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q   <= refresh_period;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    assign refresh_pending = pending_q;

endmodule

// File: rtl/regime_scheduler.sv
// rtl/regime_scheduler.sv - arbitrates enum/count/refresh requests and sequences the control path
module regime_scheduler
    import regime_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] count_cycles,
    input  logic [7:0] refresh_period,
    input  logic [1:0] regime,
    input  logic       active,
    output logic [1:0] on,
    output logic       start,
    output logic [2:0] grant,
    output logic       done,
    output logic       error
);

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic       rr_q, rr_d;          // 0: favour enum, 1: favour count
    logic [2:0] lcnt_q, lcnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic       refresh_pending;
    logic       refresh_grant;
    logic [1:0] code;

    refresh_timer u_refresh_timer (
        .clk             (clk),
        .rst             (rst),
        .refresh_period  (refresh_period),
        .refresh_grant   (refresh_grant),
        .refresh_pending (refresh_pending)
    );

    assign code = grant_to_regime(grant_q);

    // Arbitration, next-state and control-path outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        lcnt_d        = lcnt_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        refresh_grant = 1'b0;
        on            = REGIME_OFF;
        start         = 1'b0;
        error         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The cycle carrying the done pulse is a dead cycle for arbitration.
                if (regime == REGIME_OFF && !done_q) begin
                    if (req[GNT_REFRESH] || refresh_pending) begin
                        grant_d       = 3'b100;
                        refresh_grant = 1'b1;
                        lcnt_d        = 3'd0;
                        state_d       = ST_LAUNCH;
                    end else if (req[GNT_ENUM] && (!req[GNT_COUNT] || !rr_q)) begin
                        grant_d = 3'b001;
                        rr_d    = 1'b1;
                        lcnt_d  = 3'd0;
                        state_d = ST_LAUNCH;
                    end else if (req[GNT_COUNT]) begin
                        grant_d = 3'b010;
                        rr_d    = 1'b0;
                        lcnt_d  = 3'd0;
                        cnt_d   = (count_cycles == 8'd0) ? 8'd1 : count_cycles;
                        state_d = ST_LAUNCH;
                    end
                end
            end

            ST_LAUNCH: begin
                on = code;
                if (lcnt_q == LAUNCH_TIMEOUT) begin
                    error   = 1'b1;
                    grant_d = 3'b000;
                    state_d = ST_IDLE;
                end else if (regime == code) begin
                    case (code)
                        REGIME_ENUM:  state_d = ST_ENUM_START;
                        REGIME_COUNT: state_d = ST_RUN_COUNT;
                        default:      state_d = ST_RUN_REFRESH;
                    endcase
                end else begin
                    lcnt_d = lcnt_q + 3'd1;
                end
            end

            ST_ENUM_START: begin
                start = 1'b1;
                if (active) begin
                    state_d = ST_RUN_ENUM;
                end
            end

            ST_RUN_COUNT: begin
                start = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_RUN_ENUM, ST_DRAIN, ST_RUN_REFRESH: begin
                if (regime == REGIME_OFF) begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // State, grant and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            rr_q    <= 1'b0;
            lcnt_q  <= 3'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lcnt_q  <= lcnt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;

endmodule

// File: tb/tb_regime_scheduler.sv
// tb/tb_regime_scheduler.sv - directed self-checking bench for regime_scheduler
module tb_regime_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] count_cycles;
    logic [7:0] refresh_period;
    logic [1:0] regime;
    logic       active;
    logic [1:0] on;
    logic       start;
    logic [2:0] grant;
    logic       done;
    logic       error;

    logic       stuck;
    logic [1:0] hold;

    int tests = 0;
    int fails = 0;

    regime_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .count_cycles   (count_cycles),
        .refresh_period (refresh_period),
        .regime         (regime),
        .active         (active),
        .on             (on),
        .start          (start),
        .grant          (grant),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    // Control-path model: echoes on into regime, raises active on start, then returns to OFF.
    always @(posedge clk) begin
        if (!rst || stuck) begin
            regime <= 2'd0;
            active <= 1'b0;
            hold   <= 2'd0;
        end else if (on != 2'd0) begin
            regime <= on;
        end else begin
            case (regime)
                2'd1: begin
                    if (start) begin
                        active <= 1'b1;
                    end else if (active) begin
                        if (hold == 2'd1) begin
                            regime <= 2'd0;
                            active <= 1'b0;
                            hold   <= 2'd0;
                        end else begin
                            hold <= hold + 2'd1;
                        end
                    end
                end
                2'd2: if (!start) regime <= 2'd0;
                2'd3: regime <= 2'd0;
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] period);
        rst            = 1'b0;
        req            = 3'b000;
        refresh_period = period;
        step();
        step();
        rst = 1'b1;
    endtask

    // Waits for a grant, profiles the operation until its done pulse, and checks the pulse shape.
    task automatic run_op(input logic [2:0] rq, input bit drop, output logic [2:0] g,
                          output int on_c, output int st_c, output int ok);
        int n;
        bit stable;
        req = rq;
        g = 3'b000; on_c = 0; st_c = 0; ok = 0; stable = 1; n = 0;
        while (grant == 3'b000 && n < 200) begin
            step();
            n++;
        end
        g = grant;
        if (drop) req = 3'b000;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (on != 2'd0) on_c++;
            if (start) st_c++;
            if (grant !== g || error !== 1'b0) stable = 0;
            step();
            n++;
        end
        ok = (done === 1'b1 && grant === 3'b000 && stable && g != 3'b000) ? 1 : 0;
        step();
        if (done !== 1'b0) ok = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] g;
        logic [2:0] exp_nr;
        int on_c, st_c, ok, n, dones, newg, refs;
        logic [2:0] prev_g;

        stuck        = 1'b0;
        count_cycles = 8'd0;

        // Reset state
        do_reset(8'd0);
        chk("reset_on", on, 2'd0);
        chk("reset_start", start, 1'b0);
        chk("reset_grant", grant, 3'b000);
        chk("reset_done", done, 1'b0);
        chk("reset_error", error, 1'b0);

        // Enum operation, request dropped right after grant
        run_op(3'b001, 1, g, on_c, st_c, ok);
        chk("enum_grant", g, 3'b001);
        chk("enum_on_cycles", on_c, 2);
        chk("enum_start_cycles", st_c, 2);
        chk("enum_done_ok", ok, 1);

        // Count operation, 5 cycles
        count_cycles = 8'd5;
        run_op(3'b010, 1, g, on_c, st_c, ok);
        chk("count5_grant", g, 3'b010);
        chk("count5_start_cycles", st_c, 5);
        chk("count5_done_ok", ok, 1);

        // Count operation, zero treated as one
        count_cycles = 8'd0;
        run_op(3'b010, 1, g, on_c, st_c, ok);
        chk("count0_start_cycles", st_c, 1);
        chk("count0_done_ok", ok, 1);

        // Round-robin arbitration with both requests held
        do_reset(8'd0);
        count_cycles = 8'd3;
        exp_nr = 3'b001;
        for (int i = 0; i < 4; i++) begin
            run_op(3'b011, 0, g, on_c, st_c, ok);
            chk($sformatf("rr_grant_%0d", i), g, exp_nr);
            chk($sformatf("rr_done_%0d", i), ok, 1);
            exp_nr = (exp_nr == 3'b001) ? 3'b010 : 3'b001;
        end

        // Launch timeout: control path never echoes the regime
        do_reset(8'd0);
        stuck = 1'b1;
        req   = 3'b001;
        n = 0;
        while (grant == 3'b000 && n < 20) begin step(); n++; end
        n = 1;
        dones = 0;
        while (error !== 1'b1 && n < 20) begin
            if (done) dones++;
            step();
            n++;
        end
        chk("timeout_cycle", n, 5);
        chk("timeout_grant_held", grant, 3'b001);
        chk("timeout_done_low", done, 1'b0);
        req = 3'b000;
        step();
        chk("timeout_grant_clear", grant, 3'b000);
        chk("timeout_error_pulse", error, 1'b0);
        chk("timeout_no_done", dones + int'(done), 0);
        stuck = 1'b0;

        // Reset during RUN_COUNT
        do_reset(8'd0);
        count_cycles = 8'd10;
        req = 3'b010;
        n = 0;
        while (start !== 1'b1 && n < 20) begin step(); n++; end
        chk("rstmid_reached_count", start, 1'b1);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rstmid_on", on, 2'd0);
        chk("rstmid_start", start, 1'b0);
        chk("rstmid_grant", grant, 3'b000);
        chk("rstmid_done", done, 1'b0);
        rst = 1'b1;
        req = 3'b000;
        step();
        chk("rstmid_done_after", done, 1'b0);
        chk("rstmid_grant_after", grant, 3'b000);

        // Auto refresh timing from reset with no requests
        do_reset(8'd20);
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 20) chk("ref1_before", grant, 3'b000);
            if (i == 21) chk("ref1_grant", grant, 3'b100);
        end
        // Reload to 20; external request coincides with expiry
        dones = 0;
        for (int i = 1; i <= 21; i++) begin
            step();
            if (done) dones++;
            if (i == 20) begin
                chk("ref2_before", grant, 3'b000);
                req = 3'b100;
            end
            if (i == 21) begin
                chk("ref2_grant", grant, 3'b100);
                req = 3'b000;
            end
        end
        chk("ref1_one_done", dones, 1);
        dones = 0;
        newg  = 0;
        prev_g = grant;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) dones++;
            if (prev_g == 3'b000 && grant != 3'b000) newg++;
            prev_g = grant;
        end
        chk("ref2_single_op", newg, 0);
        chk("ref2_one_done", dones, 1);

        // Refresh interleaved with held enum/count requests
        count_cycles = 8'd2;
        exp_nr = 3'b001;
        refs = 0;
        for (int i = 0; i < 6; i++) begin
            run_op(3'b011, 0, g, on_c, st_c, ok);
            chk($sformatf("mix_done_%0d", i), ok, 1);
            if (g == 3'b100) begin
                refs++;
            end else begin
                chk($sformatf("mix_grant_%0d", i), g, exp_nr);
                exp_nr = (exp_nr == 3'b001) ? 3'b010 : 3'b001;
            end
        end
        chk("mix_refresh_seen", (refs >= 1) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
